// File: rtl/pc_unit_pkg.sv
// Shared constants, redirect-source encoding and priority decode for the fetch PC unit.
package pc_unit_pkg;

    localparam logic ChipEnable  = 1'b1;
    localparam logic ChipDisable = 1'b0;
    localparam logic Branch      = 1'b1;
    localparam logic NotBranch   = 1'b0;
    localparam logic BblEnable   = 1'b1;
    localparam logic BblDisable  = 1'b0;
    localparam logic RstEnable   = 1'b0;

    typedef enum logic [2:0] {
        SEL_HOLD,
        SEL_INC,
        SEL_FLUSH,
        SEL_BRANCH,
        SEL_LATCH,
        SEL_PEND
    } pc_sel_e;

    // Strict redirect priority: flush, direct branch, latch-in-stall, pending release, stall, step.
    function automatic pc_sel_e pick_sel(input logic flush, input logic branch,
                                         input logic bbl, input logic pending);
        pc_sel_e sel;
        sel = SEL_INC;
        if (flush)
            sel = SEL_FLUSH;
        else if (branch == Branch && bbl == BblDisable)
            sel = SEL_BRANCH;
        else if (branch == Branch)
            sel = SEL_LATCH;
        else if (pending && bbl == BblDisable)
            sel = SEL_PEND;
        else if (bbl == BblEnable)
            sel = SEL_HOLD;
        return sel;
    endfunction

endpackage

// File: rtl/pc_redirect_latch.sv
// Holds a branch redirect resolved during a stall until the stall releases.
module pc_redirect_latch
    import pc_unit_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              capture,
    input  logic              clear,
    input  logic [ADDR_W-1:0] capture_target,
    output logic              pending,
    output logic [ADDR_W-1:0] target
);

    // Newest capture wins; capture and clear are mutually exclusive by construction.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstEnable) begin
            pending <= 1'b0;
            target  <= '0;
        end else if (capture) begin
            pending <= 1'b1;
            target  <= capture_target;
        end else if (clear) begin
            pending <= 1'b0;
        end
    end

endmodule

// File: rtl/pc_unit.sv
// Fetch-stage PC register with flush/branch redirect, stall-pending latch and alignment check.
module pc_unit
    import pc_unit_pkg::*;
#(
    parameter int unsigned       ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0,
    parameter int unsigned       STEP      = 4,
    parameter bit                ALIGN_CHK = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bbl,
    input  logic              branch_flag_i,
    input  logic [ADDR_W-1:0] branch_target_i,
    input  logic              flush_i,
    input  logic [ADDR_W-1:0] flush_target_i,
    output logic [ADDR_W-1:0] pc,
    output logic              ce,
    output logic              pend_o,
    output logic              misalign_o
);

    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(STEP - 1);
    localparam logic [ADDR_W-1:0] STEP_INC   = ADDR_W'(STEP);

    pc_sel_e           sel;
    logic [ADDR_W-1:0] pend_target;
    logic [ADDR_W-1:0] raw_target;
    logic [ADDR_W-1:0] use_target;
    logic              redirect;
    logic              target_mis;
    logic              capture;
    logic              clear;

    pc_redirect_latch #(.ADDR_W(ADDR_W)) u_latch (
        .clk            (clk),
        .rst            (rst),
        .capture        (capture),
        .clear          (clear),
        .capture_target (branch_target_i),
        .pending        (pend_o),
        .target         (pend_target)
    );

    // Redirects are ignored entirely until the chip enable has risen.
    always_comb begin
        sel        = SEL_HOLD;
        raw_target = '0;
        if (ce == ChipEnable)
            sel = pick_sel(flush_i, branch_flag_i, bbl, pend_o);
        case (sel)
            SEL_FLUSH:  raw_target = flush_target_i;
            SEL_BRANCH: raw_target = branch_target_i;
            SEL_PEND:   raw_target = pend_target;
            default:    raw_target = '0;
        endcase
        redirect   = (sel == SEL_FLUSH) || (sel == SEL_BRANCH) || (sel == SEL_PEND);
        capture    = (sel == SEL_LATCH);
        clear      = redirect;
        target_mis = ALIGN_CHK && ((raw_target & ALIGN_MASK) != '0);
        use_target = ALIGN_CHK ? (raw_target & ~ALIGN_MASK) : raw_target;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstEnable) begin
            ce         <= ChipDisable;
            pc         <= RESET_VEC;
            misalign_o <= 1'b0;
        end else begin
            ce         <= ChipEnable;
            misalign_o <= redirect && target_mis;
            case (sel)
                SEL_FLUSH, SEL_BRANCH, SEL_PEND: pc <= use_target;
                SEL_INC:                         pc <= pc + STEP_INC;
                default:                         pc <= pc;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboarded random/directed bench for pc_unit against a behavioural fetch-address model.
module tb_pc_unit;

    typedef struct {
        logic [31:0] pc;
        logic        ce;
        logic        pend;
        logic        mis;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        bbl = 1'b0;
    logic        branch_flag_i = 1'b0;
    logic [31:0] branch_target_i = '0;
    logic        flush_i = 1'b0;
    logic [31:0] flush_target_i = '0;
    logic [31:0] pc;
    logic        ce;
    logic        pend_o;
    logic        misalign_o;

    int vectors = 0;
    int errors  = 0;
    exp_t sb_q[$];

    // Reference model state
    logic [31:0] m_pc   = '0;
    logic        m_ce   = 1'b0;
    logic        m_pend = 1'b0;
    logic [31:0] m_tgt  = '0;
    logic        m_mis  = 1'b0;

    pc_unit dut (
        .clk             (clk),
        .rst             (rst),
        .bbl             (bbl),
        .branch_flag_i   (branch_flag_i),
        .branch_target_i (branch_target_i),
        .flush_i         (flush_i),
        .flush_target_i  (flush_target_i),
        .pc              (pc),
        .ce              (ce),
        .pend_o          (pend_o),
        .misalign_o      (misalign_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Taking a target: misaligned low bits are dropped and flagged for that cycle.
    task automatic take(input logic [31:0] t);
        m_mis = (t % 4) != 0;
        m_pc  = t - (t % 4);
    endtask

    task automatic model_edge();
        m_mis = 1'b0;
        if (!rst) begin
            m_pc = '0; m_ce = 1'b0; m_pend = 1'b0; m_tgt = '0;
        end else if (!m_ce) begin
            m_ce = 1'b1;
        end else if (flush_i) begin
            take(flush_target_i); m_pend = 1'b0;
        end else if (branch_flag_i && !bbl) begin
            take(branch_target_i); m_pend = 1'b0;
        end else if (branch_flag_i) begin
            m_pend = 1'b1; m_tgt = branch_target_i;
        end else if (m_pend && !bbl) begin
            take(m_tgt); m_pend = 1'b0;
        end else if (!bbl) begin
            m_pc = m_pc + 32'd4;
        end
    endtask

    task automatic step();
        exp_t e;
        @(posedge clk);
        model_edge();
        e.pc = m_pc; e.ce = m_ce; e.pend = m_pend; e.mis = m_mis;
        sb_q.push_back(e);
        #1;
    endtask

    task automatic idle_inputs();
        bbl = 1'b0; branch_flag_i = 1'b0; flush_i = 1'b0;
    endtask

    // Monitor: compares each scheduled expectation on the falling edge.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            check("pc", pc, e.pc);
            check("ce", 32'(ce), 32'(e.ce));
            check("pend_o", 32'(pend_o), 32'(e.pend));
            check("misalign_o", 32'(misalign_o), 32'(e.mis));
        end
    end

    initial begin
        logic [31:0] t;
        #1;
        check("reset pc", pc, 32'h0);
        check("reset ce", 32'(ce), 32'h0);
        repeat (3) step();
        rst = 1'b1;
        repeat (5) step();                     // pc 0,4,8,C,10

        branch_flag_i = 1'b1; branch_target_i = 32'h100; step();
        idle_inputs(); step();

        bbl = 1'b1; branch_flag_i = 1'b1; branch_target_i = 32'h200; step();
        branch_flag_i = 1'b0; step(); step();
        bbl = 1'b0; step(); step();

        bbl = 1'b1; branch_flag_i = 1'b1; branch_target_i = 32'h200; step();
        branch_flag_i = 1'b0; flush_i = 1'b1; flush_target_i = 32'h8000_0180; step();
        idle_inputs(); step(); step();

        branch_flag_i = 1'b1; branch_target_i = 32'h103; step();
        idle_inputs(); step();
        branch_flag_i = 1'b1; branch_target_i = 32'hFFFF_FFFC; step();
        idle_inputs(); step(); step();

        // Misaligned pending target is flagged at release, not at latch time
        bbl = 1'b1; branch_flag_i = 1'b1; branch_target_i = 32'h302; step();
        branch_flag_i = 1'b0; step();
        bbl = 1'b0; step(); step();

        // Asynchronous reset while stalled with a pending redirect
        bbl = 1'b1; branch_flag_i = 1'b1; branch_target_i = 32'h300; step();
        branch_flag_i = 1'b0;
        sb_q.delete();
        rst = 1'b0;
        #1;
        check("async pc", pc, 32'h0);
        check("async ce", 32'(ce), 32'h0);
        check("async pend", 32'(pend_o), 32'h0);
        step(); step();
        rst = 1'b1; bbl = 1'b0;
        repeat (3) step();

        for (int i = 0; i < 2000; i++) begin
            bbl           = ($urandom_range(9) < 3);
            branch_flag_i = ($urandom_range(9) < 2);
            flush_i       = ($urandom_range(19) == 0);
            t = $urandom;
            if ($urandom_range(3) != 0) t = t & 32'hFFFF_FFFC;
            branch_target_i = t;
            t = $urandom;
            if ($urandom_range(3) != 0) t = t & 32'hFFFF_FFFC;
            flush_target_i = t;
            step();
        end
        idle_inputs();
        step();

        for (int w = 0; w < 5 && sb_q.size() > 0; w++) @(negedge clk);
        #1;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, 0 required", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
